// File: rtl/data_cache_ctrl_pkg.sv
// Shared defaults and FSM encoding for the direct-mapped write-through data cache.
package riscv_cache_pkg;
  localparam int ADDR_W_DEF  = 10;
  localparam int INDEX_W_DEF = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int LINE_WORDS  = 4;
  localparam int OFF_W       = 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
endpackage

// File: rtl/data_cache_ctrl_if.sv
// Core-side and memory-side bus of the data cache; slave = cache, master = environment.
interface data_cache_ctrl_if import riscv_cache_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              cpu_rd, cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic              mem_rd, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata
  );
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache_ctrl_line_store.sv
// Valid/tag/data arrays: combinational read, synchronous word write; only valid bits reset.
module cache_line_store import riscv_cache_pkg::*; #(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  input  logic [OFF_W-1:0]   rd_off,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [OFF_W-1:0]   wr_off,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               set_vld,
  input  logic               clr_vld,
  input  logic [TAG_W-1:0]   set_tag
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]                                vld_q;
  logic [LINES-1:0][TAG_W-1:0]                     tag_q;
  logic [LINES-1:0][LINE_WORDS-1:0][DATA_W-1:0]    data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         vld_q      <= '0;
    else if (set_vld) vld_q[idx] <= 1'b1;
    else if (clr_vld) vld_q[idx] <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en)   data_q[idx][wr_off] <= wr_data;
    if (set_vld) tag_q[idx]          <= set_tag;
  end

  assign rd_valid = vld_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx][rd_off];
endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with 4-word line fill.
module data_cache_ctrl import riscv_cache_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  data_cache_ctrl_if.slave        bus,
  output logic [15:0]             hit_cnt,
  output logic [15:0]             miss_cnt
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;

  state_t             state, nxt;
  logic [OFF_W-1:0]   fill_cnt;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [OFF_W-1:0]   req_off;
  logic               ln_valid, hit;
  logic [TAG_W-1:0]   ln_tag;
  logic [DATA_W-1:0]  ln_data;
  logic               wr_en, set_vld, clr_vld, hit_inc, miss_inc, fill_clr, fill_inc;
  logic [OFF_W-1:0]   wr_off;
  logic [DATA_W-1:0]  wr_data;

  // The core holds its request while stalled, so the live address doubles as the request address.
  assign {req_tag, req_idx, req_off} = bus.cpu_addr;
  assign hit = ln_valid && (ln_tag == req_tag);

  cache_line_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_store (
    .clk(clk), .rst(rst), .idx(req_idx), .rd_off(req_off),
    .rd_valid(ln_valid), .rd_tag(ln_tag), .rd_data(ln_data),
    .wr_en(wr_en), .wr_off(wr_off), .wr_data(wr_data),
    .set_vld(set_vld), .clr_vld(clr_vld), .set_tag(req_tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt           = state;
    bus.cpu_stall = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    wr_en         = 1'b0;
    wr_off        = req_off;
    wr_data       = bus.cpu_wdata;
    set_vld       = 1'b0;
    clr_vld       = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    fill_clr      = 1'b0;
    fill_inc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cpu_wr) begin
          bus.cpu_stall = 1'b1;
          nxt           = WRITE;
        end else if (bus.cpu_rd) begin
          if (hit) begin
            bus.cpu_rdata = ln_data;
            hit_inc       = 1'b1;
          end else begin
            // Drop the victim's valid now so a half-filled line can never look valid.
            bus.cpu_stall = 1'b1;
            miss_inc      = 1'b1;
            fill_clr      = 1'b1;
            clr_vld       = 1'b1;
            nxt           = FILL;
          end
        end
      end
      FILL: begin
        bus.cpu_stall = 1'b1;
        bus.mem_rd    = 1'b1;
        bus.mem_addr  = {req_tag, req_idx, fill_cnt};
        if (bus.mem_ready) begin
          wr_en    = 1'b1;
          wr_off   = fill_cnt;
          wr_data  = bus.mem_rdata;
          fill_inc = 1'b1;
          if (fill_cnt == OFF_W'(LINE_WORDS - 1)) begin
            set_vld = 1'b1;
            nxt     = IDLE;
          end
        end
      end
      WRITE: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_stall = ~bus.mem_ready;
        if (bus.mem_ready) begin
          wr_en = hit;
          nxt   = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (fill_clr)      fill_cnt <= '0;
      else if (fill_inc) fill_cnt <= fill_cnt + 1'b1;
      if (hit_inc  && hit_cnt  != 16'hFFFF) hit_cnt  <= hit_cnt + 16'd1;
      if (miss_inc && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench: word-addressed memory model with 2-cycle ready, load/store tasks, hand-computed expectations.
module tb_data_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] hit_cnt, miss_cnt;
  int          nchk = 0;
  int          nerr = 0;

  logic [31:0] mem [0:1023];
  logic [9:0]  rd_log[$];
  logic [9:0]  wr_log[$];

  data_cache_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  data_cache_ctrl #(.ADDR_W(10), .INDEX_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: ready two cycles after a request is seen, one-cycle pulse.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        cnt = 0;
      end else if (rst && (bus.mem_rd || bus.mem_wr)) begin
        cnt++;
        if (cnt == 2) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_rd) begin
            bus.mem_rdata = mem[bus.mem_addr];
            rd_log.push_back(bus.mem_addr);
          end else begin
            mem[bus.mem_addr] = bus.mem_wdata;
            wr_log.push_back(bus.mem_addr);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_load(input logic [9:0] a, output logic [31:0] d, output int cyc);
    @(negedge clk);
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = a;
    cyc = 0; d = '0;
    forever begin
      #1; cyc++;
      if (!bus.cpu_stall) begin d = bus.cpu_rdata; break; end
      if (cyc > 200) begin chk("load_timeout", 32'(cyc), 32'd0); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
  endtask

  task automatic do_store(input logic [9:0] a, input logic [31:0] wd, input logic also_rd,
                          output int cyc, output logic st0);
    @(negedge clk);
    bus.cpu_wr = 1'b1; bus.cpu_rd = also_rd; bus.cpu_addr = a; bus.cpu_wdata = wd;
    cyc = 0; st0 = 1'b0;
    forever begin
      #1; cyc++;
      if (cyc == 1) st0 = bus.cpu_stall;
      if (!bus.cpu_stall) break;
      if (cyc > 200) begin chk("store_timeout", 32'(cyc), 32'd0); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          cyc, base;
    logic        st0;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(i);
    mem[10'h040] = 32'd1; mem[10'h041] = 32'd2; mem[10'h042] = 32'd3; mem[10'h043] = 32'd4;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_hit_cnt",  32'(hit_cnt),  32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_mem_rd",   32'(bus.mem_rd), 32'd0);
    chk("rst_mem_wr",   32'(bus.mem_wr), 32'd0);
    chk("rst_stall",    32'(bus.cpu_stall), 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("idle_mem_addr",  32'(bus.mem_addr), 32'd0);
    chk("idle_mem_wdata", bus.mem_wdata, 32'd0);

    // Cold miss: 4-word fill then replayed hit
    do_load(10'h040, d, cyc);
    chk("ld040_data", d, 32'd1);
    chk("ld040_cyc", 32'(cyc), 32'd13);
    chk("ld040_nrd", 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("ld040_addr", 32'(rd_log[i]), 32'h040 + 32'(i));
    chk("ld040_miss", 32'(miss_cnt), 32'd1);
    chk("ld040_hit",  32'(hit_cnt),  32'd1);

    do_load(10'h042, d, cyc);
    chk("ld042_data", d, 32'd3);
    chk("ld042_cyc", 32'(cyc), 32'd1);
    chk("ld042_hit", 32'(hit_cnt), 32'd2);
    chk("ld042_nrd", 32'(rd_log.size()), 32'd4);

    // Store hit: written through and updated in the line
    do_store(10'h041, 32'hDEAD, 1'b0, cyc, st0);
    chk("st041_stall0", 32'(st0), 32'd1);
    chk("st041_cyc", 32'(cyc), 32'd3);
    chk("st041_nwr", 32'(wr_log.size()), 32'd1);
    chk("st041_waddr", 32'(wr_log[0]), 32'h041);
    chk("st041_mem", mem[10'h041], 32'hDEAD);
    chk("st041_hit", 32'(hit_cnt), 32'd2);
    chk("st041_miss", 32'(miss_cnt), 32'd1);
    do_load(10'h041, d, cyc);
    chk("ld041_data", d, 32'hDEAD);
    chk("ld041_cyc", 32'(cyc), 32'd1);
    chk("ld041_nrd", 32'(rd_log.size()), 32'd4);

    // Conflict in the same index
    do_load(10'h140, d, cyc);
    chk("ld140_data", d, 32'h1140);
    chk("ld140_nrd", 32'(rd_log.size()), 32'd8);
    do_load(10'h040, d, cyc);
    chk("ld040b_data", d, 32'd1);
    chk("ld040b_cyc", 32'(cyc), 32'd13);
    chk("ld040b_miss", 32'(miss_cnt), 32'd3);
    chk("ld040b_hit",  32'(hit_cnt),  32'd5);

    // Store miss: no allocate
    do_store(10'h300, 32'hBEEF, 1'b0, cyc, st0);
    chk("st300_nrd", 32'(rd_log.size()), 32'd12);
    chk("st300_nwr", 32'(wr_log.size()), 32'd2);
    chk("st300_miss", 32'(miss_cnt), 32'd3);
    do_load(10'h300, d, cyc);
    chk("ld300_data", d, 32'hBEEF);
    chk("ld300_nrd", 32'(rd_log.size()), 32'd16);
    chk("ld300_miss", 32'(miss_cnt), 32'd4);
    chk("ld300_hit",  32'(hit_cnt),  32'd6);

    // Load and store together: store wins, counters untouched
    do_store(10'h042, 32'h55, 1'b1, cyc, st0);
    chk("both_hit",  32'(hit_cnt),  32'd6);
    chk("both_miss", 32'(miss_cnt), 32'd4);
    chk("both_nwr", 32'(wr_log.size()), 32'd3);
    do_load(10'h042, d, cyc);
    chk("ld042b_data", d, 32'h55);
    chk("ld042b_hit", 32'(hit_cnt), 32'd7);

    // Reset during fill after the 2nd response
    base = rd_log.size();
    @(negedge clk);
    bus.cpu_rd = 1'b1; bus.cpu_addr = 10'h200;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (rd_log.size() == base + 2) break;
      @(negedge clk);
    end
    chk("mid_fill_resp", 32'(rd_log.size()), 32'(base + 2));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("mid_rst_miss", 32'(miss_cnt), 32'd0);
    chk("mid_rst_hit",  32'(hit_cnt),  32'd0);
    @(negedge clk);
    bus.cpu_rd = 1'b0;
    rst = 1'b1;
    base = rd_log.size();
    do_load(10'h200, d, cyc);
    chk("ld200_data", d, 32'h1200);
    chk("ld200_cyc", 32'(cyc), 32'd13);
    chk("ld200_nrd", 32'(rd_log.size()), 32'(base + 4));
    chk("ld200_first", 32'(rd_log[base]), 32'h200);
    chk("ld200_last",  32'(rd_log[base + 3]), 32'h203);
    chk("ld200_miss", 32'(miss_cnt), 32'd1);
    do_load(10'h042, d, cyc);
    chk("ld042c_miss", 32'(miss_cnt), 32'd2);
    chk("ld042c_data", d, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 Parameters: ADDR_W, default 10, word address width; INDEX_W, default 5, line index width; DATA_W, default 32, word width; tag width = ADDR_W-INDEX_W-2 (3 at defaults); 4 words per line.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cpu_rd  input  1  core load request.
REQ-005 cpu_wr  input  1  core store request.
REQ-006 cpu_addr  input  ADDR_W  core word address {tag,index,offset[1:0]}.
REQ-007 cpu_wdata  input  DATA_W  store data.
REQ-008 cpu_rdata  output  DATA_W  load data, valid when cpu_rd=1 and cpu_stall=0.
REQ-009 cpu_stall  output  1  core holds request and PC while high.
REQ-010 mem_rd  output  1  main-memory word read request.
REQ-011 mem_wr  output  1  main-memory word write request.
REQ-012 mem_addr  output  ADDR_W  main-memory word address.
REQ-013 mem_wdata  output  DATA_W  main-memory write data.
REQ-014 mem_rdata  input  DATA_W  main-memory read data, valid with mem_ready.
REQ-015 mem_ready  input  1  one-cycle completion pulse for the current mem_rd/mem_wr.
REQ-016 hit_cnt, miss_cnt  output  16 each  saturating load hit/miss counters.

Function
REQ-017 Direct-mapped, 2^INDEX_W lines, write-through, no-write-allocate; FSM states IDLE, FILL, WRITE.
REQ-018 IDLE, cpu_rd, line valid and tag match: cpu_rdata = line word[offset] combinationally, cpu_stall=0, hit_cnt+1 at edge.
REQ-019 IDLE, cpu_rd, miss: cpu_stall=1 same cycle, miss_cnt+1, fill counter cleared, go FILL.
REQ-020 FILL: mem_rd=1, mem_addr={req tag,req index,fill_cnt}; each mem_ready writes mem_rdata into word fill_cnt and increments fill_cnt; on 4th mem_ready set valid, write tag, go IDLE; cpu_stall=1 throughout FILL.
REQ-021 Line valid bit set only after all 4 words received; partial line never reported as hit.
REQ-022 After FILL the replayed load hits in IDLE (hit_cnt increments); miss latency = 1 + 4 memory responses + 1 cycles.
REQ-023 IDLE, cpu_wr: go WRITE, cpu_stall=1 in the IDLE cycle; WRITE drives mem_wr=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
REQ-024 WRITE: cpu_stall = ~mem_ready; on mem_ready, if line valid and tag match, update word[offset] with cpu_wdata; go IDLE; miss leaves cache unchanged.
REQ-025 cpu_rd and cpu_wr both high: store takes priority, load ignored, no counter change.
REQ-026 mem_ready outside FILL/WRITE ignored; mem_rd and mem_wr never both high.
REQ-027 Counters saturate at 16'hFFFF, no wrap.
REQ-028 Idle outputs: mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, cpu_stall=0 when no request.

Reset
REQ-029 rst low: state IDLE, all valid bits 0, fill_cnt 0, hit_cnt 0, miss_cnt 0, mem_rd/mem_wr 0, immediately, including mid-FILL or mid-WRITE; tag/data arrays not reset.
REQ-030 First request after reset release is always a miss.

Structure
REQ-031 Shared package riscv_cache_pkg holds parameter defaults, state enumeration, line-words constant (4).
REQ-032 One sub-module cache_line_store: valid/tag/data arrays, combinational read, synchronous word write, valid clear on reset.

Verification
REQ-033 Reset, load addr 0x040 with memory word 0x040..0x043 = 1,2,3,4, mem_ready 2 cycles after each request -> 4 mem_rd reads at 0x040..0x043, cpu_rdata=1, miss_cnt=1, hit_cnt=1.
REQ-034 Then load 0x042 -> no stall, cpu_rdata=3, hit_cnt=2.
REQ-035 Store 0x041 data 0xDEAD (hit) -> mem_wr at 0x041, stall until mem_ready; then load 0x041 -> 0xDEAD without memory access.
REQ-036 Load 0x140 (same index, tag differs) -> miss, line replaced; load 0x040 -> miss again, miss_cnt=3.
REQ-037 Store 0x300 (miss) -> mem_wr only, no fill; subsequent load 0x300 -> miss with fill.
REQ-038 Assert rst after 2nd fill response -> mem_rd drops at once, valid cleared; reload same address -> full 4-word fill.
